fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between the instruction fetch stage and decode. Each cycle, fetch offers one {pc, instr} pair. The queue stores up to DEPTH pairs in a circular buffer and presents them to decode in order, using valid/ready handshakes on both sides. A synchronous flush discards all buffered instructions for branch redirects.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 16, program-counter width
- INSTR_W, 16, instruction width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an entry this cycle
- in_ready  out  1  queue accepts an entry this cycle
- in_pc  in  PC_W  address of offered instruction
- in_instr  in  INSTR_W  offered instruction word
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  PC_W  head entry address
- out_instr  out  INSTR_W  head entry instruction
- flush  in  1  discard all entries at next edge
- count  out  $clog2(DEPTH)+1  occupied entries
- err  out  1  sticky: misaligned PC accepted

## Operation
- Pointers: rd_ptr and wr_ptr, each $clog2(DEPTH)+1 bits including a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - count = wr_ptr − rd_ptr, modulo 2^(ptr width).
- Push when in_valid && in_ready: write {in_pc, in_instr} to mem[wr_ptr index], then wr_ptr+1.
- Pop when out_valid && out_ready: rd_ptr+1.
- in_ready = !full && !flush.
  - When full, a simultaneous pop does not enable a push.
  - There is no combinational path from out_ready to in_ready.
- out_valid = !empty && !flush. out_pc and out_instr are driven from mem[rd_ptr index].
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- Flush has priority over push and pop. At the next edge rd_ptr = wr_ptr = 0. Entries offered or consumed in the flush cycle are not transferred.
- err is set when an accepted push has in_pc[0] = 1.
  - The entry is still stored.
  - err is cleared only by reset; flush does not clear it.
- Pointers wrap naturally at 2·DEPTH. The wrap bit alone distinguishes full from empty.

## Timing
- Reset (rst = 0, asynchronous) forces:
  - pointers = 0 and count = 0
  - out_valid = 0, in_ready = 1, err = 0
  - all storage = 0, so out_pc = 0 and out_instr = 0
- Latency without bypass: an entry pushed at edge N is visible on out_valid after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- Flush asserted in cycle N:
  - in_ready and out_valid are 0 during cycle N.
  - From cycle N+1: count = 0, in_ready = 1.
- Reset asserted mid-operation loses all entries immediately. There is no partial drain.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when the queue is empty and flush = 0:
  - out_valid = in_valid, out_pc = in_pc, out_instr = in_instr, all combinationally.
  - If out_ready = 1 in that cycle, the entry is consumed directly and not written; pointers do not move.
  - If out_ready = 0, the entry is written normally.
  - This gives zero-cycle latency through an empty queue.
- FETCH_QUEUE_BYPASS_EN undefined: there is no in→out combinational path, and minimum latency is 1 cycle.
- The err check applies to bypassed entries as well.

## Structure
- Shared package fetch_pkg contains:
  - PC_W and INSTR_W defaults
  - typedef fetch_entry_t, packed as {pc, instr}
  - localparam helper for pointer width
- Sub-module fetch_queue_ptr: a wrap-bit pointer register with async active-low reset, increment enable and synchronous clear. It is instantiated twice, once for rd_ptr and once for wr_ptr.

## Test plan
- Reset then idle: count = 0, out_valid = 0, in_ready = 1, err = 0, out_pc = 0 and out_instr = 0.
- Fill with out_ready = 0: push pc 0x0000, 0x0002, 0x0004, 0x0006 with instrs 0xA001–0xA004.
  - After the 4th push: count = 4, in_ready = 0.
  - A 5th offer (pc 0x0008) is not accepted.
- Drain: out_ready = 1 for 4 cycles.
  - Outputs appear in order 0x0000/0xA001 … 0x0006/0xA004.
  - Then out_valid = 0 and count = 0.
- Streaming wrap: in_valid = out_ready = 1 for 10 cycles with pc incrementing by 2.
  - count stays at 1 after the first cycle.
  - out_pc lags in_pc by exactly 1 cycle, or 0 cycles with FETCH_QUEUE_BYPASS_EN.
  - No entry is lost across the pointer wrap.
- Flush: with 3 entries held, assert flush with in_valid = 1 (pc 0x0040).
  - Next cycle: count = 0, out_valid = 0.
  - pc 0x0040 is never output.
- Misaligned PC: push pc 0x0003.
  - err = 1 from the following cycle.
  - The entry is still output.
  - err stays 1 after a flush and clears only on rst = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: default widths, the stored entry
// layout and the pointer-width helper.
package fetch_pkg;

   localparam int DEF_DEPTH   = 4;
   localparam int DEF_PC_W    = 16;
   localparam int DEF_INSTR_W = 16;

   // One queue slot, packed as {pc, instr}.
   typedef struct packed {
      logic [DEF_PC_W-1:0]    pc;
      logic [DEF_INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Pointers carry one extra wrap bit above the slot index.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle. The slave modport is the queue; the
// master modport is the environment that drives fetch and decode.
// Handshake: a transfer happens on a rising edge exactly when valid and
// ready are both high; valid never depends on ready on the same side.
interface fetch_queue_if #(
   parameter int PC_W    = fetch_pkg::DEF_PC_W,
   parameter int INSTR_W = fetch_pkg::DEF_INSTR_W
);
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr
   );

   modport master (
      output in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr
   );
endinterface

// File: rtl/fetch_queue_ptr.sv
// Wrap-bit pointer register: async active-low reset, synchronous clear
// (takes priority) and increment enable. Wraps naturally at 2**W.
module fetch_queue_ptr #(
   parameter int W = fetch_pkg::DEF_PTR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] ptr
);

   // Pointer state: clear beats increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      ptr <= '0;
      else if (clr)  ptr <= '0;
      else if (inc)  ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of {pc, instr} between fetch and decode with
// synchronous flush and a sticky misaligned-PC flag.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for a zero-latency path
// through an empty queue.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int PC_W    = DEF_PC_W,
   parameter int INSTR_W = DEF_INSTR_W,
   localparam int PTR_W  = ptr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   fetch_queue_if.slave      bus,
   input  logic              flush,
   output logic [PTR_W-1:0]  count,
   output logic              err
);

   localparam int IDX_W = PTR_W - 1;
   localparam int ENT_W = PC_W + INSTR_W;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [ENT_W-1:0] head;
   logic             empty, full;
   logic             push, wr_en, rd_inc, byp_take;

   assign rd_idx = rd_ptr[IDX_W-1:0];
   assign wr_idx = wr_ptr[IDX_W-1:0];
   assign head   = mem[rd_idx];

   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_idx == wr_idx) && (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]);
   assign count = wr_ptr - rd_ptr;

   // Full blocks a push even if decode pops this cycle, so in_ready never
   // depends on out_ready.
   assign bus.in_ready = !full && !flush;
   assign push         = bus.in_valid && bus.in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic byp;
   assign byp           = empty && !flush;
   assign bus.out_valid = !flush && (!empty || bus.in_valid);
   assign bus.out_pc    = byp ? bus.in_pc    : head[ENT_W-1:INSTR_W];
   assign bus.out_instr = byp ? bus.in_instr : head[INSTR_W-1:0];
   // Entry handed straight to decode: never written, pointers stay put.
   assign byp_take      = byp && bus.in_valid && bus.out_ready;
`else
   assign bus.out_valid = !empty && !flush;
   assign bus.out_pc    = head[ENT_W-1:INSTR_W];
   assign bus.out_instr = head[INSTR_W-1:0];
   assign byp_take      = 1'b0;
`endif

   assign wr_en  = push && !byp_take;
   assign rd_inc = bus.out_valid && bus.out_ready && !empty;

   fetch_queue_ptr #(.W(PTR_W)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_inc),
      .clr (flush),
      .ptr (rd_ptr)
   );

   fetch_queue_ptr #(.W(PTR_W)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_en),
      .clr (flush),
      .ptr (wr_ptr)
   );

   // Storage: cleared by reset so the head reads zero when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= {bus.in_pc, bus.in_instr};
      end
   end

   // Sticky misaligned-PC flag; covers bypassed entries, survives flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    err <= 1'b0;
      else if (push && bus.in_pc[0]) err <= 1'b1;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit after inputs settle.
module tb_fetch_queue;
   import fetch_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic [2:0] count;
   logic       err;
   int         n_cmp = 0;
   int         n_fail = 0;

   fetch_queue_if #(.PC_W(16), .INSTR_W(16)) bus ();

   fetch_queue #(.DEPTH(4), .PC_W(16), .INSTR_W(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .flush (flush),
      .count (count),
      .err   (err)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 0;
      flush = 0; rst = 0;
      #12;
      rst = 1;
      step();
      n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
      n_cmp++; if (bus.out_pc !== 16'h0) begin n_fail++; $display("FAIL reset_out_pc got=%h exp=0000", bus.out_pc); end
      n_cmp++; if (bus.out_instr !== 16'h0) begin n_fail++; $display("FAIL reset_out_instr got=%h exp=0000", bus.out_instr); end
   endtask

   task automatic test_fill();
      bus.out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1; bus.in_pc = 16'(2 * i); bus.in_instr = 16'(16'hA001 + i);
         settle();
         n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
         step();
      end
      bus.in_valid = 1; bus.in_pc = 16'h0008; bus.in_instr = 16'hA005;
      settle();
      n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_in_ready got=%b exp=0", bus.in_ready); end
      step();
      bus.in_valid = 0;
      settle();
      n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_rejected count got=%0d exp=4", count); end
   endtask

   task automatic test_drain();
      fetch_entry_t exp_q[$];
      fetch_entry_t e;
      for (int i = 0; i < 4; i++) exp_q.push_back('{pc: 16'(2 * i), instr: 16'(16'hA001 + i)});
      bus.out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         settle();
         e = exp_q.pop_front();
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, bus.out_valid); end
         n_cmp++; if (bus.out_pc !== e.pc) begin n_fail++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, bus.out_pc, e.pc); end
         n_cmp++; if (bus.out_instr !== e.instr) begin n_fail++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, bus.out_instr, e.instr); end
         step();
      end
      settle();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", count); end
      bus.out_ready = 0;
   endtask

   task automatic test_stream();
      logic [15:0] exp_pc;
      logic [2:0]  exp_cnt;
      bus.out_ready = 1;
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = 1; bus.in_pc = 16'(16'h0100 + 2 * k); bus.in_instr = 16'(16'hB000 + k);
         settle();
         if (BYP) begin
            exp_pc = 16'(16'h0100 + 2 * k);
            exp_cnt = 3'd0;
         end else begin
            exp_pc = 16'(16'h0100 + 2 * (k - 1));
            exp_cnt = (k == 0) ? 3'd0 : 3'd1;
         end
         n_cmp++; if (count !== exp_cnt) begin n_fail++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", k, count, exp_cnt); end
         if (BYP || k > 0) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, bus.out_valid); end
            n_cmp++; if (bus.out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, bus.out_pc, exp_pc); end
         end else begin
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid got=%b exp=0", bus.out_valid); end
         end
         step();
      end
      bus.in_valid = 0;
      settle();
      if (!BYP) begin
         n_cmp++; if (bus.out_pc !== 16'h0112) begin n_fail++; $display("FAIL stream_last_pc got=%h exp=0112", bus.out_pc); end
      end
      step();
      n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_end_count got=%0d exp=0", count); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got=%b exp=0", bus.out_valid); end
      bus.out_ready = 0;
   endtask

   task automatic test_flush();
      bus.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1; bus.in_pc = 16'(16'h0020 + 2 * i); bus.in_instr = 16'(16'hD000 + i);
         step();
      end
      bus.in_valid = 0;
      settle();
      n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
      flush = 1; bus.in_valid = 1; bus.in_pc = 16'h0040; bus.in_instr = 16'hD040;
      settle();
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
      step();
      flush = 0; bus.in_valid = 0;
      settle();
      n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_post_in_ready got=%b exp=1", bus.in_ready); end
      bus.out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_0040[%0d] valid got=%b exp=0 pc=%h", i, bus.out_valid, bus.out_pc); end
      end
      bus.out_ready = 0;
   endtask

   task automatic test_misaligned();
      bus.out_ready = 0; bus.in_valid = 1; bus.in_pc = 16'h0003; bus.in_instr = 16'hC003;
      settle();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL misalign_pre_err got=%b exp=0", err); end
      step();
      bus.in_valid = 0;
      settle();
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_err got=%b exp=1", err); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL misalign_valid got=%b exp=1", bus.out_valid); end
      n_cmp++; if (bus.out_pc !== 16'h0003) begin n_fail++; $display("FAIL misalign_pc got=%h exp=0003", bus.out_pc); end
      n_cmp++; if (bus.out_instr !== 16'hC003) begin n_fail++; $display("FAIL misalign_instr got=%h exp=C003", bus.out_instr); end
      bus.out_ready = 1;
      step();
      bus.out_ready = 0; flush = 1;
      step();
      flush = 0;
      settle();
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_after_flush got=%b exp=1", err); end
      rst = 0;
      settle();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL misalign_after_reset got=%b exp=0", err); end
      n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL misalign_reset_count got=%0d exp=0", count); end
      step();
      rst = 1;
      step();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_flush();
      test_misaligned();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
